// File: rtl/tcs3200_emulator_pkg.sv
// Shared encodings for the TCS3200 emulator and the colour front-end.
package tcs3200_emulator_pkg;

  localparam int HALF_W_DEF = 16;

  // s2_s3 photodiode filter select
  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_CLEAR = 2'b10;
  localparam logic [1:0] FILT_GREEN = 2'b11;

  // s0_s1 output frequency scaling
  localparam logic [1:0] SCL_OFF = 2'b00;
  localparam logic [1:0] SCL_2   = 2'b01;
  localparam logic [1:0] SCL_20  = 2'b10;
  localparam logic [1:0] SCL_100 = 2'b11;

  // half-period multiplier for each scaling (lower frequency -> longer half)
  localparam int MUL_OFF = 0;
  localparam int MUL_2   = 50;
  localparam int MUL_20  = 5;
  localparam int MUL_100 = 1;

  typedef enum logic [1:0] {
    OFF    = 2'b00,
    SETTLE = 2'b01,
    RUN    = 2'b10
  } state_t;

endpackage

// File: rtl/tcs3200_emulator_if.sv
// Sensor-side pins plus the intensity write port.
interface tcs3200_emulator_if
  import tcs3200_emulator_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEF
);
  logic [1:0]        s0_s1;
  logic [1:0]        s2_s3;
  logic              wr_en;
  logic [1:0]        wr_sel;
  logic [HALF_W-1:0] wr_data;
  logic              sensor_out;
  logic              out_valid;
  logic              settling;

  modport master (
    output s0_s1, s2_s3, wr_en, wr_sel, wr_data,
    input  sensor_out, out_valid, settling
  );

  modport slave (
    input  s0_s1, s2_s3, wr_en, wr_sel, wr_data,
    output sensor_out, out_valid, settling
  );
endinterface

// File: rtl/tcs3200_emulator_scale_mul.sv
// Half-period times scaling multiplier; shift-add keeps it multiplier-free.
module tcs_scale_mul
  import tcs3200_emulator_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEF
) (
  input  logic [HALF_W-1:0] half,
  input  logic [1:0]        scl,
  output logic [HALF_W+5:0] product
);
  logic [HALF_W+5:0] h_ext;

  assign h_ext = {6'b000000, half};

  // x1 / x5 = 4+1 / x50 = 32+16+2 / x0
  always_comb begin
    product = '0;
    case (scl)
      SCL_100: product = h_ext;
      SCL_20:  product = (h_ext << 2) + h_ext;
      SCL_2:   product = (h_ext << 5) + (h_ext << 4) + (h_ext << 1);
      default: product = '0;
    endcase
  end
endmodule

// File: rtl/tcs3200_emulator.sv
// TCS3200 sensor emulator: square wave whose half-period is the programmed
// channel intensity times the scaling factor, with a settle gap after any
// select-line change.
module tcs3200_emulator
  import tcs3200_emulator_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int DEFAULT_HALF  = 100,
  parameter int HALF_W        = 16
) (
  input logic clk,
  input logic rst,
  tcs3200_emulator_if.slave bus
);
  localparam int TW = HALF_W + 6;

  state_t            state, state_nx;
  logic [3:0]        cfg_q;
  logic [TW-1:0]     counter, counter_nx;
  logic [TW-1:0]     target_q, target_nx, target;
  logic              sout_q, sout_nx;
  logic [HALF_W-1:0] half [4];
  logic              cfg_change;

  assign cfg_change = ({bus.s0_s1, bus.s2_s3} != cfg_q);

  // target always follows the stored config, so it is stable through SETTLE
  tcs_scale_mul #(.HALF_W(HALF_W)) u_mul (
    .half    (half[cfg_q[1:0]]),
    .scl     (cfg_q[3:2]),
    .product (target)
  );

  // intensity registers, writable in every state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) half[i] <= HALF_W'(DEFAULT_HALF);
    end else if (bus.wr_en) begin
      half[bus.wr_sel] <= bus.wr_data;
    end
  end

  // state, config and timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= OFF;
      cfg_q    <= '0;
      counter  <= '0;
      target_q <= '0;
      sout_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      cfg_q    <= {bus.s0_s1, bus.s2_s3};
      counter  <= counter_nx;
      target_q <= target_nx;
      sout_q   <= sout_nx;
    end
  end

  // next-state: a config change restarts everything, else normal sequencing
  always_comb begin
    state_nx   = state;
    counter_nx = counter;
    target_nx  = target_q;
    sout_nx    = sout_q;
    if (cfg_change) begin
      counter_nx = '0;
      sout_nx    = 1'b0;
      state_nx   = (bus.s0_s1 == SCL_OFF) ? OFF : SETTLE;
    end else begin
      case (state)
        OFF: begin
          sout_nx    = 1'b0;
          counter_nx = '0;
        end
        SETTLE: begin
          sout_nx = 1'b0;
          if (counter == TW'(SETTLE_CYCLES - 1)) begin
            state_nx   = RUN;
            counter_nx = '0;
            target_nx  = target;
          end else begin
            counter_nx = counter + 1'b1;
          end
        end
        RUN: begin
          if (target_q == '0) begin
            // dark channel: hold low and keep polling for a nonzero target
            sout_nx    = 1'b0;
            counter_nx = '0;
            target_nx  = target;
          end else if (counter == target_q - 1'b1) begin
            sout_nx    = ~sout_q;
            counter_nx = '0;
            target_nx  = target;
          end else begin
            counter_nx = counter + 1'b1;
          end
        end
        default: begin
          state_nx   = OFF;
          counter_nx = '0;
          sout_nx    = 1'b0;
        end
      endcase
    end
  end

  assign bus.sensor_out = sout_q;
  assign bus.out_valid  = (state == RUN);
  assign bus.settling   = (state == SETTLE);
endmodule
